// File: rtl/ram_rr_arbiter.sv
// Round-robin arbiter sharing one simple dual-port RAM between two clients.
// Read data is broadcast; a tag pipeline steers rvalid back to the issuer.
module ram_rr_arbiter #(
   parameter int RAM_WIDTH  = 8,
   parameter int ADDR_WIDTH = 9,
   parameter int RD_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  c0_req,
   input  logic                  c0_we,
   input  logic [ADDR_WIDTH-1:0] c0_addr,
   input  logic [RAM_WIDTH-1:0]  c0_wdata,
   output logic                  c0_gnt,
   output logic                  c0_rvalid,
   output logic [RAM_WIDTH-1:0]  c0_rdata,
   input  logic                  c1_req,
   input  logic                  c1_we,
   input  logic [ADDR_WIDTH-1:0] c1_addr,
   input  logic [RAM_WIDTH-1:0]  c1_wdata,
   output logic                  c1_gnt,
   output logic                  c1_rvalid,
   output logic [RAM_WIDTH-1:0]  c1_rdata,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [RAM_WIDTH-1:0]  ram_wr_data,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [RAM_WIDTH-1:0]  ram_rd_data
);

   logic                  last_q, last_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [RAM_WIDTH-1:0]  wr_data_q, wr_data_d;
   logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
   logic                  rd_id_q, rd_id_d;
   logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d;
   logic [RD_LATENCY-1:0] tag_id_q, tag_id_d;

   logic                  gnt0, gnt1;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [RAM_WIDTH-1:0]  sel_wdata;

   // last_q = 1 means client 1 was granted last, so client 0 wins a tie
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (rst_n) begin
         gnt0 = c0_req && (!c1_req || last_q);
         gnt1 = c1_req && !gnt0;
      end
   end

   always_comb begin
      sel_we    = gnt1 ? c1_we    : c0_we;
      sel_addr  = gnt1 ? c1_addr  : c0_addr;
      sel_wdata = gnt1 ? c1_wdata : c0_wdata;
   end

   always_comb begin
      last_d    = last_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      rd_addr_d = rd_addr_q;
      rd_id_d   = rd_id_q;
      if (gnt0 || gnt1) begin
         last_d = gnt1;
         if (sel_we) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_wdata;
         end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = sel_addr;
            rd_id_d   = gnt1;
         end
      end
   end

   // Tags ride alongside the RAM read so rvalid lines up with ram_rd_data
   always_comb begin
      tag_vld_d    = tag_vld_q;
      tag_id_d     = tag_id_q;
      tag_vld_d[0] = rd_en_q;
      tag_id_d[0]  = rd_id_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_vld_d[i] = tag_vld_q[i-1];
         tag_id_d[i]  = tag_id_q[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_q    <= 1'b1;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         rd_addr_q <= '0;
         rd_id_q   <= 1'b0;
         tag_vld_q <= '0;
         tag_id_q  <= '0;
      end else begin
         last_q    <= last_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         rd_addr_q <= rd_addr_d;
         rd_id_q   <= rd_id_d;
         tag_vld_q <= tag_vld_d;
         tag_id_q  <= tag_id_d;
      end
   end

   assign c0_gnt      = gnt0;
   assign c1_gnt      = gnt1;
   assign ram_wr_en   = wr_en_q;
   assign ram_wr_addr = wr_addr_q;
   assign ram_wr_data = wr_data_q;
   assign ram_rd_en   = rd_en_q;
   assign ram_rd_addr = rd_addr_q;
   assign c0_rdata    = ram_rd_data;
   assign c1_rdata    = ram_rd_data;
   assign c0_rvalid   = rst_n && tag_vld_q[RD_LATENCY-1]
                        && !tag_id_q[RD_LATENCY-1];
   assign c1_rvalid   = rst_n && tag_vld_q[RD_LATENCY-1]
                        && tag_id_q[RD_LATENCY-1];

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Scoreboard bench: two arbiters (read latency 1 and 3) share one stimulus
// stream; a reference model predicts grants, RAM commands and read returns.
module tb_ram_rr_arbiter;

   localparam int AW   = 9;
   localparam int DW   = 8;
   localparam int LATA = 1;
   localparam int LATB = 3;

   typedef struct {
      logic [DW-1:0] data;
      int            cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [1:0]    req = '0;
   logic [1:0]    we = '0;
   logic [AW-1:0] addr [2];
   logic [DW-1:0] wd [2];

   logic [1:0]    g_a, rv_a, g_b, rv_b;
   logic [DW-1:0] rd0_a, rd1_a, rd0_b, rd1_b;
   logic          we_a, re_a, we_b, re_b;
   logic [AW-1:0] wa_a, ra_a, wa_b, ra_b;
   logic [DW-1:0] wdat_a, wdat_b, ramd_a, ramd_b;

   ram_rr_arbiter #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LATA)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_wdata(wd[0]),
      .c0_gnt(g_a[0]), .c0_rvalid(rv_a[0]), .c0_rdata(rd0_a),
      .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_wdata(wd[1]),
      .c1_gnt(g_a[1]), .c1_rvalid(rv_a[1]), .c1_rdata(rd1_a),
      .ram_wr_en(we_a), .ram_wr_addr(wa_a), .ram_wr_data(wdat_a),
      .ram_rd_en(re_a), .ram_rd_addr(ra_a), .ram_rd_data(ramd_a)
   );

   ram_rr_arbiter #(.RAM_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(LATB)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .c0_req(req[0]), .c0_we(we[0]), .c0_addr(addr[0]), .c0_wdata(wd[0]),
      .c0_gnt(g_b[0]), .c0_rvalid(rv_b[0]), .c0_rdata(rd0_b),
      .c1_req(req[1]), .c1_we(we[1]), .c1_addr(addr[1]), .c1_wdata(wd[1]),
      .c1_gnt(g_b[1]), .c1_rvalid(rv_b[1]), .c1_rdata(rd1_b),
      .ram_wr_en(we_b), .ram_wr_addr(wa_b), .ram_wr_data(wdat_b),
      .ram_rd_en(re_b), .ram_rd_addr(ra_b), .ram_rd_data(ramd_b)
   );

   // RAM models: latency 1 and latency 3
   logic [DW-1:0] mem_a [512];
   logic [DW-1:0] mem_b [512];
   logic [DW-1:0] pipe_b [3];

   always @(posedge clk) begin
      if (we_a) mem_a[wa_a] <= wdat_a;
      if (re_a) ramd_a <= mem_a[ra_a];
   end

   always @(posedge clk) begin
      if (we_b) mem_b[wa_b] <= wdat_b;
      if (re_b) pipe_b[0] <= mem_b[ra_b];
      pipe_b[1] <= pipe_b[0];
      pipe_b[2] <= pipe_b[1];
   end
   assign ramd_b = pipe_b[2];

   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h required 0x%0h at cycle %0d",
                  nm, act, exp, cyc);
      end
   endfunction

   // Reference model: memory contents as seen by the serialized command stream
   logic [DW-1:0] mem_m [512];
   logic          last = 1'b1;
   int            cmd_k = 0;
   logic [AW-1:0] cmd_a = '0;
   logic [DW-1:0] cmd_d = '0;
   logic [1:0]    granted = '0;

   // index = dut*2 + client
   exp_t q [4][$];

   function automatic void flush();
      for (int i = 0; i < 4; i++) q[i].delete();
   endfunction

   task automatic step();
      logic g0, g1;
      int c, nk;
      logic [AW-1:0] na;
      logic [DW-1:0] nd;
      exp_t e;
      nk = 0;
      na = '0;
      nd = '0;
      @(negedge clk);
      if (!rst_n) flush();
      g0 = rst_n && req[0] && (!req[1] || last);
      g1 = rst_n && req[1] && !g0;
      chk("gnt_a", 32'(g_a), 32'({g1, g0}));
      chk("gnt_b", 32'(g_b), 32'({g1, g0}));
      chk("wr_en_a", 32'(we_a), 32'(cmd_k == 1));
      chk("rd_en_a", 32'(re_a), 32'(cmd_k == 2));
      chk("wr_en_b", 32'(we_b), 32'(cmd_k == 1));
      chk("rd_en_b", 32'(re_b), 32'(cmd_k == 2));
      if (cmd_k == 1) begin
         chk("wr_addr_a", 32'(wa_a), 32'(cmd_a));
         chk("wr_data_a", 32'(wdat_a), 32'(cmd_d));
         chk("wr_addr_b", 32'(wa_b), 32'(cmd_a));
      end
      if (cmd_k == 2) begin
         chk("rd_addr_a", 32'(ra_a), 32'(cmd_a));
         chk("rd_addr_b", 32'(ra_b), 32'(cmd_a));
      end
      if (g0 || g1) begin
         c = g1 ? 1 : 0;
         last = g1;
         na = addr[c];
         if (we[c]) begin
            mem_m[addr[c]] = wd[c];
            nk = 1;
            nd = wd[c];
         end else begin
            nk = 2;
            e.data = mem_m[addr[c]];
            e.cyc = cyc + 1 + LATA;
            q[c].push_back(e);
            e.cyc = cyc + 1 + LATB;
            q[2 + c].push_back(e);
         end
      end
      granted = {g1, g0};
      @(posedge clk);
      if (!rst_n) begin
         last = 1'b1;
         cmd_k = 0;
         flush();
      end else begin
         cmd_k = nk;
         cmd_a = na;
         cmd_d = nd;
      end
      #1;
   endtask

   task automatic mon(int i, logic rv, logic [DW-1:0] rd);
      exp_t e;
      if (rv) begin
         if (q[i].size() == 0) begin
            chk($sformatf("spurious_rvalid[%0d]", i), 32'(rv), 32'd0);
         end else begin
            e = q[i].pop_front();
            chk($sformatf("rvalid_cycle[%0d]", i), 32'(cyc), 32'(e.cyc));
            chk($sformatf("rdata[%0d]", i), 32'(rd), 32'(e.data));
         end
      end else if (q[i].size() != 0 && q[i][0].cyc <= cyc) begin
         chk($sformatf("missed_rvalid[%0d]", i), 32'(rv), 32'd1);
         void'(q[i].pop_front());
      end
   endtask

   always @(negedge clk) begin
      #1;
      mon(0, rv_a[0], rd0_a);
      mon(1, rv_a[1], rd1_a);
      mon(2, rv_b[0], rd0_b);
      mon(3, rv_b[1], rd1_b);
   end

   task automatic xfer(int c, logic w, logic [AW-1:0] a, logic [DW-1:0] d);
      req[c] = 1'b1;
      we[c] = w;
      addr[c] = a;
      wd[c] = d;
      for (int k = 0; k < 8; k++) begin
         step();
         if (granted[c]) break;
      end
      chk("gnt_wait", 32'(granted[c]), 32'd1);
      req[c] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 512; i++) mem_m[i] = '0;
      addr[0] = '0; addr[1] = '0;
      wd[0] = '0; wd[1] = '0;
      @(posedge clk);
      #1;
      req = 2'b11;
      step();
      step();
      req = 2'b00;
      rst_n = 1'b1;

      for (int a = 0; a < 16; a++) xfer(0, 1'b1, AW'(a), 8'h00);
      xfer(0, 1'b1, 9'd10, 8'h3c);
      xfer(0, 1'b1, 9'd20, 8'hc3);

      xfer(0, 1'b1, 9'd100, 8'd6);
      repeat (2) step();
      xfer(0, 1'b0, 9'd100, 8'd0);
      repeat (5) step();

      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      req = 2'b11;
      we = 2'b00;
      addr[0] = 9'd10;
      addr[1] = 9'd20;
      for (int k = 0; k < 6; k++) begin
         step();
         chk("contention_order", 32'(granted), (k % 2 == 0) ? 32'd1 : 32'd2);
      end
      req = 2'b00;
      repeat (5) step();

      for (int i = 0; i < 8; i++) begin
         req[1] = 1'b1;
         we[1] = (i < 4);
         addr[1] = AW'(i % 4);
         wd[1] = 8'hA0 + 8'(i % 4);
         step();
         chk("b2b_gnt", 32'(granted[1]), 32'd1);
      end
      req = 2'b00;
      repeat (5) step();

      req[0] = 1'b1; we[0] = 1'b1; addr[0] = 9'd5; wd[0] = 8'h55;
      step();
      req[0] = 1'b0;
      req[1] = 1'b1; we[1] = 1'b0; addr[1] = 9'd5;
      step();
      req[1] = 1'b0;
      repeat (5) step();

      req[0] = 1'b1; we[0] = 1'b0; addr[0] = 9'd7;
      step();
      req[0] = 1'b0;
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      req = 2'b11;
      we = 2'b00;
      addr[0] = 9'd1;
      addr[1] = 9'd2;
      step();
      chk("post_reset_c0_first", 32'(granted), 32'd1);
      step();
      req = 2'b00;
      repeat (5) step();

      for (int n = 0; n < 1500; n++) begin
         for (int c = 0; c < 2; c++) begin
            if (granted[c] || !req[c]) begin
               req[c] = ($urandom_range(3) != 0);
               we[c] = 1'($urandom_range(1));
               addr[c] = AW'($urandom_range(15));
               wd[c] = DW'($urandom);
            end
         end
         step();
      end
      req = 2'b00;
      repeat (10) step();
      for (int i = 0; i < 4; i++)
         chk($sformatf("drain[%0d]", i), 32'(q[i].size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one simple dual-port RAM (8x512 default) between two requesters, client 0 and client 1.
- Grants at most one access per cycle to either a write or a read, using round-robin priority.
- Drives the RAM write and read ports from a single clock domain.
- Routes read data back to the issuing client with a valid strobe, accounting for the RAM read latency.

Parameters:
- RAM_WIDTH, 8: data width of the RAM and of both client data buses.
- ADDR_WIDTH, 9: address width of the RAM and of both client address buses.
- RD_LATENCY, 1: cycles from ram_rd_en high to valid ram_rd_data. Legal range is 1 to 4.

Ports:
- clk, input, 1: single clock. Also drives the RAM's write and read clocks.
- rst_n, input, 1: reset, synchronous and active-low.
- c0_req, input, 1: client 0 access request. Held with c0_we, c0_addr and c0_wdata until c0_gnt.
- c0_we, input, 1: 1 = write, 0 = read.
- c0_addr, input, ADDR_WIDTH: access address.
- c0_wdata, input, RAM_WIDTH: write data.
- c0_gnt, output, 1: request accepted this cycle (combinational).
- c0_rvalid, output, 1: c0_rdata holds the result of a client 0 read.
- c0_rdata, output, RAM_WIDTH: read data return.
- c1_req, c1_we, c1_addr, c1_wdata, c1_gnt, c1_rvalid, c1_rdata: same as the c0_* ports, for client 1.
- ram_wr_en, output, 1: RAM write enable.
- ram_wr_addr, output, ADDR_WIDTH: RAM write address.
- ram_wr_data, output, RAM_WIDTH: RAM write data.
- ram_rd_en, output, 1: RAM read enable.
- ram_rd_addr, output, ADDR_WIDTH: RAM read address.
- ram_rd_data, input, RAM_WIDTH: RAM read data.

Behaviour:
- Reset (rst_n low at a rising edge):
  - Registered outputs clear to 0: ram_wr_en, ram_rd_en, ram_wr_addr, ram_wr_data, ram_rd_addr.
  - Last-grant pointer resets to 1, so client 0 has first priority.
  - Read-tag pipeline clears.
  - c0_gnt, c1_gnt, c0_rvalid and c1_rvalid are forced to 0 while rst_n is low.
- Arbitration (combinational, per cycle):
  - Only one requester asserted: it is granted.
  - Both asserted: the client not granted last is granted.
  - Neither asserted: no grant, pointer unchanged.
  - At most one gnt is high per cycle.
  - The pointer updates on the edge where a grant occurs.
- Handshake:
  - A transfer occurs on the rising edge where cX_req and cX_gnt are both 1.
  - Clients must hold req and the payload stable until granted. Changing the payload before the grant is a protocol violation; behaviour is undefined.
  - A client may keep req high for back-to-back accesses. Under contention it is granted every other cycle.
- Command issue, 1 cycle after the grant cycle:
  - Granted write: ram_wr_en = 1, ram_wr_addr/ram_wr_data = granted payload; ram_rd_en = 0.
  - Granted read: ram_rd_en = 1, ram_rd_addr = granted address; ram_wr_en = 0.
  - No grant: both enables 0. Address/data registers hold their last values.
  - ram_wr_en and ram_rd_en are never both 1.
- Read return:
  - A tag (valid + client id) enters a RD_LATENCY-deep shift pipeline alongside ram_rd_en.
  - Exactly RD_LATENCY cycles after the cycle ram_rd_en = 1, the matching cX_rvalid is high for one cycle.
  - c0_rdata and c1_rdata both equal ram_rd_data at all times; only rvalid is steered.
  - Overall read latency is 1 + RD_LATENCY cycles from the grant cycle to the rvalid cycle.
  - Reads issue at up to one per cycle. Returns are in issue order with no reordering.
- Hazards:
  - A write granted in cycle N, followed by a read of the same address granted in cycle N+1 or later, returns the new data.
  - The arbiter adds no bypass; the one-command-per-cycle serialization guarantees this ordering.
- Reset mid-operation: in-flight read tags are discarded, and no rvalid fires after reset deasserts for reads issued before reset.

Test Plan:
- Single write then read (client 0):
  - Stimulus: write addr 100, data 6; later read addr 100.
  - Response: ram_wr_en pulses once with addr 100, data 6. c0_rvalid is high 2 cycles after the read grant with c0_rdata = 6 (RD_LATENCY = 1). c1_rvalid stays 0.
- Contention:
  - Stimulus: c0 and c1 both hold req for 6 cycles, both reads, addresses 10 and 20.
  - Response: grants alternate c0, c1, c0, c1, c0, c1 (first grant to c0 after reset). Each client's rvalid pulses three times with its own data.
- Back-to-back solo:
  - Stimulus: c1 alone writes addresses 0..3 with data 0xA0..0xA3 on consecutive cycles, then reads 0..3.
  - Response: c1_gnt is high every cycle. Reads return 0xA0..0xA3 on 4 consecutive c1_rvalid cycles.
- Write-then-read hazard:
  - Stimulus: c0 writes addr 5 = 0x55 in cycle N; c1 reads addr 5 in cycle N+1.
  - Response: c1_rdata = 0x55 with c1_rvalid.
- Reset mid-read:
  - Stimulus: grant a read, then pull rst_n low the next cycle for 2 cycles.
  - Response: no rvalid ever appears for that read. All RAM enables are 0 during reset. c0 wins the first contention after reset.
- Latency parameter:
  - Stimulus: RD_LATENCY = 3 with a RAM model of matching latency; single read.
  - Response: rvalid appears exactly 4 cycles after the grant, with correct data.
